// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_ctrl
//  Purpose  : LED bank mode sequencer. One shared prescaler timebase paces
//             four display modes: IDLE, BLINK, FLOW, BOUNCE.
//  Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
  parameter int                 CNT_W   = 25,
  parameter logic [CNT_W-1:0]   CNT_MAX = 25'd24_999_999,
  parameter int                 LED_W   = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             mode_next,
  input  logic             pause_tgl,
  output logic [LED_W-1:0] led_out,
  output logic [1:0]       mode,
  output logic             paused,
  output logic             tick
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLINK  = 2'd1,
    ST_FLOW   = 2'd2,
    ST_BOUNCE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - CNT_ONE;
  localparam logic [LED_W-1:0] LED_LSB   = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic             DIR_LEFT  = 1'b0;
  localparam logic             DIR_RIGHT = 1'b1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               paused_q, paused_d;
  logic               dir_q, dir_d;
  logic [LED_W-1:0]   led_q, led_d;

  // State registers; asynchronous reset returns every output to zero at once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      paused_q <= 1'b0;
      dir_q    <= DIR_LEFT;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      paused_q <= paused_d;
      dir_q    <= dir_d;
      led_q    <= led_d;
    end
  end

  // Next-state: mode advance wins over everything, else timebase + pattern.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    paused_d = paused_q;
    dir_d    = dir_q;
    led_d    = led_q;

    if (mode_next) begin
      // Entry edge: restart the timebase and load the new mode's pattern.
      cnt_d    = '0;
      paused_d = 1'b0;
      dir_d    = DIR_LEFT;
      case (state_q)
        ST_IDLE:  begin state_d = ST_BLINK;  led_d = '0;      end
        ST_BLINK: begin state_d = ST_FLOW;   led_d = LED_LSB; end
        ST_FLOW:  begin state_d = ST_BOUNCE; led_d = LED_LSB; end
        default:  begin state_d = ST_IDLE;   led_d = '0;      end
      endcase
    end else if (state_q == ST_IDLE) begin
      cnt_d    = '0;
      paused_d = 1'b0;
      dir_d    = DIR_LEFT;
      led_d    = '0;
    end else begin
      // A pending tick always consumes its count, even if a pause has just
      // started, so the held count after a pause never loses a period.
      if (!paused_q || tick_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
      end
      tick_d = !paused_q && (cnt_q == CNT_PRE);

      if (tick_q) begin
        case (state_q)
          ST_BLINK: led_d = ~led_q;
          ST_FLOW:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          default: begin
            if (dir_q == DIR_LEFT) begin
              led_d = {led_q[LED_W-2:0], 1'b0};
              if (led_q[LED_W-2]) dir_d = DIR_RIGHT;
            end else begin
              led_d = {1'b0, led_q[LED_W-1:1]};
              if (led_q[1]) dir_d = DIR_LEFT;
            end
          end
        endcase
      end

      // Pause toggles after any tick-driven update in the same cycle.
      if (pause_tgl) paused_d = ~paused_q;
    end
  end

  assign led_out = led_q;
  assign mode    = state_q;
  assign paused  = paused_q;
  assign tick    = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_seq_ctrl
//  Purpose  : Scoreboard bench for led_seq_ctrl (CNT_MAX=4, LED_W=4).
//             Stimulus pushes cycle-tagged expectations; a monitor compares
//             them one step after each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       mode_next;
  logic       pause_tgl;
  logic [3:0] led_out;
  logic [1:0] mode;
  logic       paused;
  logic       tick;

  led_seq_ctrl #(
    .CNT_W   (3),
    .CNT_MAX (3'd4),
    .LED_W   (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mode_next (mode_next),
    .pause_tgl (pause_tgl),
    .led_out   (led_out),
    .mode      (mode),
    .paused    (paused),
    .tick      (tick)
  );

  typedef struct {
    int         t;
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;
    logic       tick;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 sys_clk = ~sys_clk;

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic void cmp(string tag, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d: got led=%b mode=%0d paused=%b tick=%b, required led=%b mode=%0d paused=%b tick=%b",
               tag, cyc, act[7:4], act[3:2], act[1], act[0], req[7:4], req[3:2], req[1], req[0]);
    end
  endfunction

  task automatic push(int t, logic [3:0] l, logic [1:0] m, logic p, logic tk, string tag);
    exp_t e;
    e.t = t; e.led = l; e.mode = m; e.paused = p; e.tick = tk; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_to(int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  // Present inputs so they are sampled on rising edge t.
  task automatic drive_at(int t, logic mn, logic pt);
    wait_to(t - 1);
    mode_next = mn;
    pause_tgl = pt;
    @(negedge sys_clk);
    mode_next = 1'b0;
    pause_tgl = 1'b0;
  endtask

  // Monitor: compare every expectation tagged for this edge.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].t == cyc) begin
          cmp(sb[i].tag, {led_out, mode, paused, tick},
              {sb[i].led, sb[i].mode, sb[i].paused, sb[i].tick});
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base, e0, f0, g0, h0, b0;
    logic [3:0] l;
    logic [3:0] bseq [10];
    bseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
             4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    sys_rst_n = 1'b0;
    mode_next = 1'b0;
    pause_tgl = 1'b0;
    repeat (3) @(negedge sys_clk);
    cmp("reset_state", {led_out, mode, paused, tick}, 8'h00);
    sys_rst_n = 1'b1;

    // IDLE: nothing moves, pause request ignored.
    base = cyc;
    for (int k = 1; k <= 20; k++) push(base + k, 4'b0000, 2'd0, 1'b0, 1'b0, "idle");
    drive_at(base + 5, 1'b0, 1'b1);
    wait_to(base + 20);

    // BLINK: ticks at 4,9,14 after entry, toggles at 5,10,15.
    e0 = cyc + 1;
    for (int k = 0; k <= 15; k++)
      push(e0 + k, ((k / 5) % 2 == 1) ? 4'b1111 : 4'b0000, 2'd1, 1'b0, (k % 5 == 4), "blink");
    drive_at(e0, 1'b1, 1'b0);
    wait_to(e0 + 15);

    // FLOW with a 7-cycle pause starting where cnt==2, then rotation wrap.
    f0 = cyc + 1;
    for (int k = 0; k <= 31; k++) begin
      if (k <= 4)       l = 4'b0001;
      else if (k <= 16) l = 4'b0010;
      else if (k <= 21) l = 4'b0100;
      else if (k <= 26) l = 4'b1000;
      else              l = 4'b0001;
      push(f0 + k, l, 2'd2, (k >= 8 && k <= 14),
           (k == 4 || k == 16 || k == 21 || k == 26 || k == 31), "flow_pause");
    end
    // mode_next + pause_tgl coinciding with a tick: enter BOUNCE clean.
    g0 = f0 + 32;
    for (int k = 0; k <= 6; k++)
      push(g0 + k, (k < 5) ? 4'b0001 : 4'b0010, 2'd3, 1'b0, (k == 4), "prio_entry");
    // One-cycle reset mid-BOUNCE, then plain IDLE.
    for (int k = 7; k <= 10; k++) push(g0 + k, 4'b0000, 2'd0, 1'b0, 1'b0, "post_reset");

    drive_at(f0, 1'b1, 1'b0);
    drive_at(f0 + 8, 1'b0, 1'b1);
    drive_at(f0 + 15, 1'b0, 1'b1);
    drive_at(g0, 1'b1, 1'b1);
    wait_to(g0 + 6);
    #2;
    sys_rst_n = 1'b0;
    #1;
    cmp("async_reset", {led_out, mode, paused, tick}, 8'h00);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Three back-to-back mode_next pulses from IDLE land in BOUNCE.
    h0 = g0 + 11;
    b0 = h0 + 2;
    push(h0,     4'b0000, 2'd1, 1'b0, 1'b0, "step_blink");
    push(h0 + 1, 4'b0001, 2'd2, 1'b0, 1'b0, "step_flow");
    for (int k = 0; k <= 44; k++)
      push(b0 + k, bseq[k / 5], 2'd3, 1'b0, (k % 5 == 4), "bounce");
    // tick and pause_tgl together: update first, then pause; resume at +48.
    for (int k = 45; k <= 53; k++)
      push(b0 + k, (k == 53) ? 4'b0100 : 4'b1000, 2'd3, (k <= 47), (k == 52), "tick_pause");

    wait_to(h0 - 1);
    mode_next = 1'b1;
    repeat (3) @(negedge sys_clk);
    mode_next = 1'b0;
    drive_at(b0 + 45, 1'b0, 1'b1);
    drive_at(b0 + 48, 1'b0, 1'b1);
    wait_to(b0 + 55);

    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL unchecked %s: expectation for cyc=%0d never compared (now cyc=%0d)",
               sb[i].tag, sb[i].t, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
